// File: rtl/mips32_alu_pkg.sv
// Shared MIPS32 ALU definitions: datapath width, word type and add/sub opcode.
package mips32_alu_pkg;

  localparam int unsigned XLEN = 32;

  typedef logic [XLEN-1:0] word_t;

  typedef enum logic {
    ALU_OP_ADD = 1'b0,
    ALU_OP_SUB = 1'b1
  } alu_op_e;

endpackage

// File: rtl/pipelined_addsub_if.sv
// Handshake bundle for the pipelined add/sub unit.
//   Input side : in_valid/in_ready, a, b, sub, cin
//   Output side: out_valid/out_ready, y, cout, ovf, zero
// master = requester/consumer, slave = the arithmetic unit.
interface pipelined_addsub_if
  import mips32_alu_pkg::*;
#(
  parameter int unsigned WIDTH = XLEN
);

  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             sub;
  logic             cin;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] y;
  logic             cout;
  logic             ovf;
  logic             zero;

  modport master (
    output in_valid, a, b, sub, cin, out_ready,
    input  in_ready, out_valid, y, cout, ovf, zero
  );

  modport slave (
    input  in_valid, a, b, sub, cin, out_ready,
    output in_ready, out_valid, y, cout, ovf, zero
  );

endinterface

// File: rtl/pipelined_addsub_slice.sv
// addsub_slice: combinational SW-bit full adder, one per pipeline stage.
//   a, b : slice operands     ci : carry in
//   s    : slice sum          co : carry out
module addsub_slice #(
  parameter int unsigned SW = 8
) (
  input  logic [SW-1:0] a,
  input  logic [SW-1:0] b,
  input  logic          ci,
  output logic [SW-1:0] s,
  output logic          co
);

  assign {co, s} = (SW+1)'(a) + (SW+1)'(b) + (SW+1)'(ci);

endmodule

// File: rtl/pipelined_addsub.sv
// pipelined_addsub: WIDTH-bit add/subtract split into STAGES carry-chained
// slices, one slice per cycle, with valid/ready handshakes and global stall.
//   clk, rst_n : clock, asynchronous active-low reset
//   bus        : slave side of pipelined_addsub_if (operands in, result+flags out)
// Result y is registered with cout, ovf and zero; latency is STAGES cycles.
module pipelined_addsub
  import mips32_alu_pkg::*;
#(
  parameter int unsigned WIDTH  = XLEN,
  parameter int unsigned STAGES = 4
) (
  input  logic            clk,
  input  logic            rst_n,
  pipelined_addsub_if.slave bus
);

  localparam int unsigned SW = WIDTH / STAGES;

  if (STAGES == 0 || STAGES > WIDTH || (WIDTH % STAGES) != 0) begin : g_param_chk
    $error("pipelined_addsub: WIDTH must be a multiple of STAGES, 1 <= STAGES <= WIDTH");
  end

  logic             adv;
  logic             out_v;
  logic [WIDTH-1:0] y_q;
  logic             cout_q;
  logic             ovf_q;
  logic             zero_q;
  logic [WIDTH-1:0] a_in;
  logic [WIDTH-1:0] b_eff;
  logic             cin_eff;

  // Whole pipeline advances unless a valid result is being held back.
  assign adv          = !out_v || bus.out_ready;
  assign bus.in_ready = adv;

  assign a_in    = bus.a;
  assign b_eff   = (bus.sub == ALU_OP_SUB) ? ~bus.b : bus.b;
  assign cin_eff = (bus.sub == ALU_OP_SUB) ? 1'b1 : bus.cin;

  // Stage k consumes the lowest remaining operand slice; the registers carry
  // only the not-yet-added upper operand bits and the finished lower sum bits.
  for (genvar k = 0; k < STAGES; k++) begin : stg
    localparam int unsigned UW = WIDTH - k * SW;
    localparam int unsigned YW = (k + 1) * SW;

    logic [UW-1:0] ua;
    logic [UW-1:0] ub;
    logic          ci;
    logic          vi;
    logic [SW-1:0] s;
    logic          co;
    logic [YW-1:0] y_nxt;

    if (k == 0) begin : g_in
      assign ua    = a_in;
      assign ub    = b_eff;
      assign ci    = cin_eff;
      assign vi    = bus.in_valid;
      assign y_nxt = s;
    end else begin : g_chain
      assign ua    = stg[k-1].g_reg.r_a;
      assign ub    = stg[k-1].g_reg.r_b;
      assign ci    = stg[k-1].g_reg.r_c;
      assign vi    = stg[k-1].g_reg.r_v;
      assign y_nxt = {s, stg[k-1].g_reg.r_y};
    end

    addsub_slice #(.SW(SW)) u_slice (
      .a  (ua[SW-1:0]),
      .b  (ub[SW-1:0]),
      .ci (ci),
      .s  (s),
      .co (co)
    );

    // Inter-stage register; the last stage writes the output registers instead.
    if (k < STAGES - 1) begin : g_reg
      logic [UW-SW-1:0] r_a;
      logic [UW-SW-1:0] r_b;
      logic [YW-1:0]    r_y;
      logic             r_c;
      logic             r_v;

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          r_a <= '0;
          r_b <= '0;
          r_y <= '0;
          r_c <= 1'b0;
          r_v <= 1'b0;
        end else if (adv) begin
          r_a <= ua[UW-1:SW];
          r_b <= ub[UW-1:SW];
          r_y <= y_nxt;
          r_c <= co;
          r_v <= vi;
        end
      end
    end
  end

  logic [WIDTH-1:0] y_last;
  logic             co_last;
  logic             v_last;
  logic             a_msb;
  logic             b_msb;

  assign y_last  = stg[STAGES-1].y_nxt;
  assign co_last = stg[STAGES-1].co;
  assign v_last  = stg[STAGES-1].vi;
  assign a_msb   = stg[STAGES-1].ua[SW-1];
  assign b_msb   = stg[STAGES-1].ub[SW-1];

  // Output register: result and flags, held while out_valid && !out_ready.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_v  <= 1'b0;
      y_q    <= '0;
      cout_q <= 1'b0;
      ovf_q  <= 1'b0;
      zero_q <= 1'b0;
    end else if (adv) begin
      out_v  <= v_last;
      y_q    <= y_last;
      cout_q <= co_last;
      ovf_q  <= (a_msb == b_msb) && (y_last[WIDTH-1] != a_msb);
      zero_q <= ~|y_last;
    end
  end

  assign bus.out_valid = out_v;
  assign bus.y         = y_q;
  assign bus.cout      = cout_q;
  assign bus.ovf       = ovf_q;
  assign bus.zero      = zero_q;

endmodule

// File: tb/tb_pipelined_addsub.sv
// Self-checking bench: four instances (STAGES 4,1,2,8) share one stimulus
// stream; expected results are logged when an operand set is accepted and
// compared in order when each instance presents a result.
module tb_pipelined_addsub;
  import mips32_alu_pkg::*;

  localparam int unsigned NI = 4;

  typedef struct {
    word_t y;
    logic  c;
    logic  o;
    logic  z;
    int    acc;
  } exp_t;

  logic  clk;
  logic  rst_n;
  logic  drv_valid;
  word_t drv_a;
  word_t drv_b;
  logic  drv_sub;
  logic  drv_cin;
  logic  drv_out_ready;
  logic  chk_lat;
  logic  [NI-1:0] ready_vec;
  logic  all_ready;

  int    cyc = 0;
  int    errors = 0;
  int    checks = 0;
  exp_t  exp_log[$];
  int    rd_idx[NI];
  bit    bp_done;

  assign all_ready = &ready_vec;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic exp_t mk(input word_t y, input logic c, input logic o, input logic z);
    exp_t e;
    e.y = y; e.c = c; e.o = o; e.z = z; e.acc = 0;
    return e;
  endfunction

  function automatic exp_t model(input word_t a, input word_t b, input logic sub, input logic cin);
    logic [XLEN:0] s;
    word_t be;
    exp_t e;
    be = sub ? ~b : b;
    s  = {1'b0, a} + {1'b0, be} + (XLEN+1)'(sub ? 1'b1 : cin);
    e.y = s[XLEN-1:0];
    e.c = s[XLEN];
    e.o = (a[XLEN-1] == be[XLEN-1]) && (e.y[XLEN-1] != a[XLEN-1]);
    e.z = (e.y == '0);
    e.acc = 0;
    return e;
  endfunction

  function automatic word_t rnd_word();
    case ($urandom_range(0, 7))
      0:       return 32'h0000_0000;
      1:       return 32'hFFFF_FFFF;
      2:       return 32'h8000_0000;
      3:       return 32'h7FFF_FFFF;
      default: return word_t'($urandom);
    endcase
  endfunction

  for (genvar gi = 0; gi < NI; gi++) begin : g_dut
    localparam int unsigned ST = (gi == 0) ? 4 : (gi == 1) ? 1 : (gi == 2) ? 2 : 8;

    pipelined_addsub_if #(.WIDTH(XLEN)) bus ();

    assign bus.in_valid  = drv_valid && all_ready;
    assign bus.a         = drv_a;
    assign bus.b         = drv_b;
    assign bus.sub       = drv_sub;
    assign bus.cin       = drv_cin;
    assign bus.out_ready = drv_out_ready;
    assign ready_vec[gi] = bus.in_ready;

    pipelined_addsub #(.WIDTH(XLEN), .STAGES(ST)) u_dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
    );

    exp_t e;

    // Sample just before the next rising edge; compare against the log head
    // every cycle a result is shown, pop it only when it is accepted.
    always begin
      @(negedge clk);
      #2;
      if (!rst_n) begin
        rd_idx[gi] = exp_log.size();
      end else if (bus.out_valid) begin
        if (rd_idx[gi] >= exp_log.size()) begin
          check($sformatf("s%0d_spurious", ST), 64'(1), 64'(0));
        end else begin
          e = exp_log[rd_idx[gi]];
          check($sformatf("s%0d_y", ST),    64'(bus.y),    64'(e.y));
          check($sformatf("s%0d_cout", ST), 64'(bus.cout), 64'(e.c));
          check($sformatf("s%0d_ovf", ST),  64'(bus.ovf),  64'(e.o));
          check($sformatf("s%0d_zero", ST), 64'(bus.zero), 64'(e.z));
          if (bus.out_ready) begin
            if (chk_lat) check($sformatf("s%0d_latency", ST), 64'(cyc - e.acc), 64'(ST));
            rd_idx[gi] = rd_idx[gi] + 1;
          end
        end
      end
    end
  end

  task automatic send(input word_t a, input word_t b, input logic sub, input logic cin, input exp_t e);
    int   n;
    bit   ok;
    exp_t en;
    n = 0;
    ok = 1'b0;
    en = e;
    @(negedge clk);
    drv_a = a; drv_b = b; drv_sub = sub; drv_cin = cin; drv_valid = 1'b1;
    while (!ok && n < 100) begin
      #1;
      ok = all_ready;
      en.acc = cyc;
      @(posedge clk);
      n++;
      if (!ok) @(negedge clk);
    end
    if (ok) exp_log.push_back(en);
    else begin
      check("send_timeout", 64'(0), 64'(1));
      drv_valid = 1'b0;
    end
  endtask

  task automatic send_rnd();
    word_t a, b;
    logic  s, c;
    a = rnd_word(); b = rnd_word();
    s = 1'($urandom_range(0, 1)); c = 1'($urandom_range(0, 1));
    send(a, b, s, c, model(a, b, s, c));
  endtask

  task automatic idle();
    @(negedge clk);
    drv_valid = 1'b0;
  endtask

  task automatic drain();
    int n;
    bit done;
    n = 0;
    done = 1'b0;
    while (!done && n < 200) begin
      @(negedge clk);
      #3;
      done = 1'b1;
      for (int i = 0; i < NI; i++) if (rd_idx[i] != exp_log.size()) done = 1'b0;
      n++;
    end
    check("drain", 64'(done), 64'(1));
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    clk = 1'b0; rst_n = 1'b0; drv_valid = 1'b0;
    drv_a = '0; drv_b = '0; drv_sub = 1'b0; drv_cin = 1'b0;
    drv_out_ready = 1'b1; chk_lat = 1'b0; bp_done = 1'b0;
    for (int i = 0; i < NI; i++) rd_idx[i] = 0;

    // Reset state
    repeat (3) @(negedge clk);
    #1;
    check("rst_out_valid", 64'(g_dut[0].bus.out_valid), 64'(0));
    check("rst_y",         64'(g_dut[0].bus.y),         64'(0));
    check("rst_cout",      64'(g_dut[0].bus.cout),      64'(0));
    check("rst_zero",      64'(g_dut[0].bus.zero),      64'(0));
    check("rst_in_ready",  64'(g_dut[0].bus.in_ready),  64'(1));
    check("rst_s8_valid",  64'(g_dut[3].bus.out_valid), 64'(0));
    @(negedge clk);
    rst_n = 1'b1;

    // Directed add/sub cases with explicit expectations
    chk_lat = 1'b1;
    send(32'h0000_FFFF, 32'h0000_0001, 1'b0, 1'b0, mk(32'h0001_0000, 1'b0, 1'b0, 1'b0));
    send(32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, mk(32'h8000_0000, 1'b0, 1'b1, 1'b0));
    send(32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, mk(32'h0000_0000, 1'b1, 1'b0, 1'b1));
    send(32'h0000_0005, 32'h0000_0007, 1'b1, 1'b0, mk(32'hFFFF_FFFE, 1'b0, 1'b0, 1'b0));
    send(32'h8000_0000, 32'h0000_0001, 1'b1, 1'b0, mk(32'h7FFF_FFFF, 1'b1, 1'b1, 1'b0));
    send(32'h0000_0001, 32'h0000_0001, 1'b0, 1'b1, mk(32'h0000_0003, 1'b0, 1'b0, 1'b0));
    send(32'h0000_0005, 32'h0000_0005, 1'b1, 1'b0, mk(32'h0000_0000, 1'b1, 1'b0, 1'b1));
    send(32'h1234_5678, 32'h0000_0000, 1'b1, 1'b0, mk(32'h1234_5678, 1'b1, 1'b0, 1'b0));
    idle();
    drain();

    // Back-to-back stream with a 3-cycle output stall in the middle
    chk_lat = 1'b0;
    fork
      begin
        for (int i = 0; i < 8; i++) begin
          word_t a, b;
          a = 32'h0101_0101 * word_t'(i + 1);
          b = 32'h00F0_0F0F + word_t'(i);
          send(a, b, 1'(i % 2), 1'b1, model(a, b, 1'(i % 2), 1'b1));
        end
        idle();
      end
      begin
        repeat (6) @(negedge clk);
        drv_out_ready = 1'b0;
        repeat (3) begin
          #1;
          check("stall_in_ready", 64'(g_dut[0].bus.in_ready), 64'(0));
          @(negedge clk);
        end
        drv_out_ready = 1'b1;
      end
    join
    drain();

    // Reset with operations in flight
    chk_lat = 1'b1;
    send(32'h0000_0010, 32'h0000_0020, 1'b0, 1'b0, mk(32'h0000_0030, 1'b0, 1'b0, 1'b0));
    send(32'h0000_0100, 32'h0000_0200, 1'b0, 1'b0, mk(32'h0000_0300, 1'b0, 1'b0, 1'b0));
    send(32'h0000_1000, 32'h0000_2000, 1'b0, 1'b0, mk(32'h0000_3000, 1'b0, 1'b0, 1'b0));
    @(negedge clk);
    drv_valid = 1'b0;
    @(negedge clk);
    #1;
    check("pre_rst_valid", 64'(g_dut[0].bus.out_valid), 64'(1));
    rst_n = 1'b0;
    #1;
    check("mid_rst_valid", 64'(g_dut[0].bus.out_valid), 64'(0));
    check("mid_rst_y",     64'(g_dut[0].bus.y),         64'(0));
    check("mid_rst_s8",    64'(g_dut[3].bus.out_valid), 64'(0));
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("post_rst_ready", 64'(g_dut[0].bus.in_ready), 64'(1));
    repeat (12) begin
      @(negedge clk);
      #1;
      check("post_rst_s4_idle", 64'(g_dut[0].bus.out_valid), 64'(0));
      check("post_rst_s8_idle", 64'(g_dut[3].bus.out_valid), 64'(0));
    end
    send(32'hDEAD_0000, 32'h0000_BEEF, 1'b0, 1'b0, mk(32'hDEAD_BEEF, 1'b0, 1'b0, 1'b0));
    idle();
    drain();

    // Random sweep without backpressure; latency checked on every result
    chk_lat = 1'b1;
    for (int i = 0; i < 1000; i++) send_rnd();
    idle();
    drain();

    // Random traffic under random backpressure
    chk_lat = 1'b0;
    fork
      begin
        for (int i = 0; i < 200; i++) send_rnd();
        idle();
        bp_done = 1'b1;
      end
      begin
        while (!bp_done) begin
          @(negedge clk);
          drv_out_ready = ($urandom_range(0, 3) != 0);
        end
        drv_out_ready = 1'b1;
      end
    join
    drain();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
